// File: rtl/fco_align_ctrl_if.sv
// Bundle between the FCO ISERDES side and the frame alignment controller.
// The controller takes the slave view; whoever supplies the frame word takes the master view.
interface fco_align_ctrl_if;
   logic [13:0] fco_pattern;
   logic        soft_start;
   logic        fco_bitslip;
   logic        fco_aligned;
   logic        fco_error;
   logic        lock_lost;
   logic [3:0]  slip_count;
   logic [6:0]  fco_fsm;

   modport master (
      output fco_pattern,
      output soft_start,
      input  fco_bitslip,
      input  fco_aligned,
      input  fco_error,
      input  lock_lost,
      input  slip_count,
      input  fco_fsm
   );

   modport slave (
      input  fco_pattern,
      input  soft_start,
      output fco_bitslip,
      output fco_aligned,
      output fco_error,
      output lock_lost,
      output slip_count,
      output fco_fsm
   );
endinterface

// File: rtl/fco_align_ctrl.sv
// Frame-clock alignment controller: bitslips the FCO ISERDES until the frame word matches,
// confirms the match, holds lock and drops it after a run of mismatching words.
module fco_align_ctrl #(
   parameter logic [13:0] FCO_PATTERN   = 14'h3F80,
   parameter int unsigned SETTLE_CYCLES = 15,
   parameter int unsigned CONFIRM_COUNT = 100,
   parameter int unsigned MAX_SLIPS     = 14,
   parameter int unsigned LOSS_COUNT    = 4
) (
   input  logic           clk_ref,
   input  logic           reset,
   fco_align_ctrl_if.slave bus
);

   localparam logic [6:0] ST_IDLE    = 7'b0000001;
   localparam logic [6:0] ST_SETTLE  = 7'b0000010;
   localparam logic [6:0] ST_CHECK   = 7'b0000100;
   localparam logic [6:0] ST_SLIP    = 7'b0001000;
   localparam logic [6:0] ST_CONFIRM = 7'b0010000;
   localparam logic [6:0] ST_LOCKED  = 7'b0100000;
   localparam logic [6:0] ST_FAIL    = 7'b1000000;

   localparam logic [7:0]  SETTLE_LOAD    = 8'(SETTLE_CYCLES);
   localparam logic [15:0] CONFIRM_LAST   = 16'(CONFIRM_COUNT - 1);
   localparam logic [3:0]  SLIP_LIMIT     = 4'(MAX_SLIPS);
   localparam logic [7:0]  LOSS_LAST      = 8'(LOSS_COUNT - 1);
   localparam bit          CONFIRM_SINGLE = (CONFIRM_COUNT == 1);

   logic [6:0]  state_reg, state_next;
   logic [7:0]  settle_reg, settle_next;
   logic [15:0] confirm_reg, confirm_next;
   logic [7:0]  loss_reg, loss_next;
   logic [3:0]  slip_reg, slip_next;
   logic        lost_next;

   logic        bitslip_reg;
   logic        aligned_reg;
   logic        error_reg;
   logic        lost_reg;

   logic [13:0] bit_match;
   logic        pattern_match;

   // Per-bit case equality so that X/Z on any input bit reads as a mismatch.
   genvar gi;
   generate
      for (gi = 0; gi < 14; gi++) begin : g_cmp
         assign bit_match[gi] = (bus.fco_pattern[gi] === FCO_PATTERN[gi]);
      end
   endgenerate

   assign pattern_match = &bit_match;

   always_comb begin
      state_next   = state_reg;
      settle_next  = settle_reg;
      confirm_next = confirm_reg;
      loss_next    = loss_reg;
      slip_next    = slip_reg;
      lost_next    = 1'b0;

      if (bus.soft_start) begin
         state_next = ST_IDLE;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               state_next  = ST_SETTLE;
               settle_next = SETTLE_LOAD;
            end

            ST_SETTLE: begin
               if (settle_reg <= 8'd1) begin
                  state_next = ST_CHECK;
               end else begin
                  settle_next = settle_reg - 8'd1;
               end
            end

            ST_CHECK: begin
               if (pattern_match) begin
                  state_next   = CONFIRM_SINGLE ? ST_LOCKED : ST_CONFIRM;
                  confirm_next = 16'd1;
               end else if (slip_reg >= SLIP_LIMIT) begin
                  state_next = ST_FAIL;
               end else begin
                  state_next = ST_SLIP;
               end
            end

            ST_SLIP: begin
               state_next  = ST_SETTLE;
               settle_next = SETTLE_LOAD;
               slip_next   = (slip_reg == 4'hF) ? slip_reg : slip_reg + 4'd1;
            end

            ST_CONFIRM: begin
               if (pattern_match) begin
                  if (confirm_reg >= CONFIRM_LAST) begin
                     state_next = ST_LOCKED;
                  end else begin
                     confirm_next = confirm_reg + 16'd1;
                  end
               end else if (slip_reg >= SLIP_LIMIT) begin
                  state_next = ST_FAIL;
               end else begin
                  state_next = ST_SLIP;
               end
            end

            ST_LOCKED: begin
               if (pattern_match) begin
                  loss_next = 8'd0;
               end else if (loss_reg >= LOSS_LAST) begin
                  state_next = ST_IDLE;
                  lost_next  = 1'b1;
               end else begin
                  loss_next = loss_reg + 8'd1;
               end
            end

            ST_FAIL: begin
               state_next = ST_FAIL;
            end

            default: begin
               state_next = ST_IDLE;
            end
         endcase
      end

      // Every path into IDLE, abort or loss of lock, restarts from clean counters.
      if (state_next == ST_IDLE) begin
         settle_next  = 8'd0;
         confirm_next = 16'd0;
         loss_next    = 8'd0;
         slip_next    = 4'd0;
      end
   end

   // Flags are registered from the next state so they line up with the state they belong to.
   always_ff @(posedge clk_ref) begin
      if (reset) begin
         state_reg   <= ST_IDLE;
         settle_reg  <= 8'd0;
         confirm_reg <= 16'd0;
         loss_reg    <= 8'd0;
         slip_reg    <= 4'd0;
         bitslip_reg <= 1'b0;
         aligned_reg <= 1'b0;
         error_reg   <= 1'b0;
         lost_reg    <= 1'b0;
      end else begin
         state_reg   <= state_next;
         settle_reg  <= settle_next;
         confirm_reg <= confirm_next;
         loss_reg    <= loss_next;
         slip_reg    <= slip_next;
         bitslip_reg <= (state_next == ST_SLIP);
         aligned_reg <= (state_next == ST_LOCKED);
         error_reg   <= (state_next == ST_FAIL);
         lost_reg    <= lost_next;
      end
   end

   assign bus.fco_bitslip = bitslip_reg;
   assign bus.fco_aligned = aligned_reg;
   assign bus.fco_error   = error_reg;
   assign bus.lock_lost   = lost_reg;
   assign bus.slip_count  = slip_reg;
   assign bus.fco_fsm     = state_reg;

endmodule
